instr_cache_ctrl: RTL and testbench
===================================

// Module: instr_cache_ctrl
// PURPOSE
//  Direct-mapped instruction cache and miss controller between the fetch stage and instr_mem.
//  Looks up PC_F each cycle and returns Instr_F on a hit.
//  On a miss it drives hit_miss low, which is the refill request to instr_mem.
//  It then waits for countdone, writes the returned 64-bit block (Instr_F1:Instr_F0) into the line, and resumes fetch.
// PARAMETERS
//  INDEX_BITS  4   line index width; NUM_LINES = 2**INDEX_BITS, each line = 2 x 32-bit words
//  CNT_W       32  width of hit/miss performance counters
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  PC_F       in   32     fetch address; bit2 = word offset, [INDEX_BITS+2:3] = index, rest = tag
//  flush      in   1      invalidate all lines (synchronous)
//  Instr_F    out  32     fetched instruction; valid when hit_miss=1
//  hit_miss   out  1      1=hit; 0=miss/refill in progress (fetch stall, and request to instr_mem)
//  mem_addr   out  32     block address of the outstanding refill, {tag,index,3'b000}
//  Instr_F1   in   32     returned block upper word (PC[2]=1)
//  Instr_F0   in   32     returned block lower word (PC[2]=0)
//  countdone  in   1      instr_mem block-ready flag
//  hit_cnt    out  CNT_W  count of cycles in IDLE with a hit, saturating
//  miss_cnt   out  CNT_W  count of misses detected, saturating
// BEHAVIOUR
//  Storage: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES][63:0].
//  Reset (async, rst_n=0): all valid=0; state=IDLE; mem_addr=0; hit_cnt=miss_cnt=0; flush_pend=0.
//   While in reset: hit_miss=0, Instr_F=0.
//  hit = (state==IDLE) & valid[idx] & (tag[idx]==PC_F tag); this is combinational.
//  hit_miss = hit. Instr_F = hit ? data[idx] word selected by PC_F[2] : 32'h0.
//  FSM:
//   IDLE: on a hit, no state change and hit_cnt++.
//    On a miss: latch mem_addr={PC_F[31:3],3'b000}, miss_cnt++, go to WAIT.
//    countdone is ignored in IDLE because it holds its stale value from the previous refill.
//   WAIT: hit_miss=0. countdone=0 -> stay.
//    countdone=1 -> write data[mem_addr idx]={Instr_F1,Instr_F0}, tag, valid=1; go to IDLE.
//  Latency:
//   hit is 0 cycles (combinational).
//   Miss against the 20-cycle instr_mem: detected in cycle 0, countdone sampled high in WAIT at cycle 20, line written at edge 21.
//   The hit appears in cycle 21 (21 stall cycles).
//  After a refill, IDLE re-looks-up the current PC_F.
//   If PC_F changed during WAIT, this may be a new miss.
//   The refill always targets the latched mem_addr, never the live PC_F.
//  flush in IDLE: clear all valid at the edge. The hit is still evaluated with pre-flush state in that cycle.
//  flush in WAIT: set flush_pend. The refill completes normally. On entry to IDLE, all valid (including the new line) is cleared and flush_pend=0.
//  Counters saturate at all-ones; they do not wrap.
//  rst_n asserted during WAIT: immediate return to IDLE with all lines invalid, and no line is written.
//   A countdone arriving after reset is ignored (IDLE).
//  An index conflict (same index, different tag) evicts the old line; there is no replacement choice.
// TESTING
//  Cold miss: reset, PC_F=0x40, memory model returns 0xBBBB0002_AAAA0001 after 20 cycles.
//   -> hit_miss=0 cycles 0-20; cycle 21 hit_miss=1, Instr_F=0xAAAA0001; miss_cnt=1.
//  Same block, other word: PC_F=0x44 right after the fill -> immediate hit, Instr_F=0xBBBB0002, no new request.
//  Conflict: fill 0x40, then PC_F=0x40+(8<<INDEX_BITS) -> miss with mem_addr=0xC0.
//   After the refill, PC_F=0x40 misses again; miss_cnt=3.
//  Stale countdone: back-to-back misses 0x40 then 0x80 with countdone still 1 from the first.
//   -> the second line is not written before the model's new countdone; the data for 0x80 is correct.
//  Flush during WAIT: miss on 0x40, pulse flush in cycle 5 -> fill completes, IDLE clears valid, PC_F=0x40 misses again.
//  Reset mid-refill: rst_n=0 at cycle 10 of WAIT -> hit_miss=0, counters=0, valid all 0.
//   A later countdone pulse writes nothing.

Source files
------------

// File: rtl/instr_cache_ctrl_if.sv
// Fetch-side and instr_mem-side signals of the instruction cache controller.
// The cache drives through the slave modport; fetch stage/instr_mem (or a bench) use master.
interface instr_cache_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      PC_F;
    logic             flush;
    logic [31:0]      Instr_F;
    logic             hit_miss;
    logic [31:0]      mem_addr;
    logic [31:0]      Instr_F1;
    logic [31:0]      Instr_F0;
    logic             countdone;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  PC_F, flush, Instr_F1, Instr_F0, countdone,
        output Instr_F, hit_miss, mem_addr, hit_cnt, miss_cnt
    );

    modport master (
        output PC_F, flush, Instr_F1, Instr_F0, countdone,
        input  Instr_F, hit_miss, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped instruction cache (2 words per line) with a single-outstanding refill FSM.
//   state | meaning
//   IDLE  | look up PC_F every cycle; a miss latches the block address and requests a refill
//   WAIT  | refill outstanding; stall fetch until countdone, then write the line
module instr_cache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 32
) (
    input logic               clk,
    input logic               rst_n,
    instr_cache_ctrl_if.slave bus
);
    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_W     = 32 - INDEX_BITS - 3;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [NUM_LINES-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [63:0]             data_q [NUM_LINES];
    logic [31:0]             mem_addr_q;
    logic [CNT_W-1:0]        hit_cnt_q, miss_cnt_q;
    logic                    flush_pend_q;

    logic [INDEX_BITS-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, fill_tag;
    logic [63:0]             line;
    logic                    hit, miss, refill;
    logic                    unused_pc_bits;

    assign idx            = bus.PC_F[INDEX_BITS+2:3];
    assign pc_tag         = bus.PC_F[31:INDEX_BITS+3];
    assign fill_idx       = mem_addr_q[INDEX_BITS+2:3];
    assign fill_tag       = mem_addr_q[31:INDEX_BITS+3];
    assign line           = data_q[idx];
    assign unused_pc_bits = ^bus.PC_F[1:0];

    assign hit = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == pc_tag);

    assign bus.hit_miss = hit;
    assign bus.Instr_F  = hit ? (bus.PC_F[2] ? line[63:32] : line[31:0]) : 32'h0;
    assign bus.mem_addr = mem_addr_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;

    // countdone is deliberately not looked at in IDLE: it still holds the previous refill's flag
    always_comb begin
        state_d = state_q;
        miss    = 1'b0;
        refill  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    miss    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.countdone) begin
                    refill  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            mem_addr_q   <= 32'h0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (hit && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);

            if (miss) begin
                mem_addr_q <= {bus.PC_F[31:3], 3'b000};
                if (miss_cnt_q != '1)
                    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end

            // A flush seen during the refill also wipes the line being filled
            if ((state_q == IDLE) && bus.flush) begin
                valid_q <= '0;
            end else if (refill) begin
                if (flush_pend_q || bus.flush)
                    valid_q <= '0;
                else
                    valid_q[fill_idx] <= 1'b1;
            end

            if (state_q == WAIT) begin
                if (refill)
                    flush_pend_q <= 1'b0;
                else if (bus.flush)
                    flush_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            data_q[fill_idx] <= {bus.Instr_F1, bus.Instr_F0};
            tag_q[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Directed bench for instr_cache_ctrl with a 20-cycle instr_mem model.
// Model data for block address A: lower = AAAA0000 ^ (A>>6), upper = BBBB0000 ^ ((A>>6)+1).
module tb_instr_cache_ctrl;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instr_cache_ctrl_if #(.CNT_W(CNT_W)) bus ();

    instr_cache_ctrl #(.INDEX_BITS(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instr_mem model; when model_en=0 the bench drives countdone/data by hand
    logic        model_en;
    logic        t_countdone;
    logic [31:0] t_f0, t_f1;
    logic        m_cd;
    int          mst;
    int          mcnt;
    logic [31:0] blk;

    assign blk           = bus.mem_addr >> 6;
    assign bus.countdone = model_en ? m_cd : t_countdone;
    assign bus.Instr_F0  = model_en ? (m_cd ? (32'hAAAA0000 ^ blk) : 32'hDEADDEAD) : t_f0;
    assign bus.Instr_F1  = model_en ? (m_cd ? (32'hBBBB0000 ^ (blk + 32'd1)) : 32'hDEADDEAD) : t_f1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst  <= 0;
            mcnt <= 0;
            m_cd <= 1'b0;
        end else begin
            case (mst)
                0: if (model_en && !bus.hit_miss) begin
                    mst  <= 1;
                    mcnt <= 1;
                    m_cd <= 1'b0;
                end
                1: if (mcnt == 19) begin
                    m_cd <= 1'b1;
                    mst  <= 2;
                end else begin
                    mcnt <= mcnt + 1;
                end
                default: mst <= 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(output int stalls);
        stalls = 0;
        while (bus.hit_miss !== 1'b1 && stalls < 100) begin
            @(posedge clk);
            #2;
            stalls++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        model_en    = 1'b1;
        t_countdone = 1'b0;
        t_f0        = 32'h0;
        t_f1        = 32'h0;
        bus.PC_F    = 32'h40;
        bus.flush   = 1'b0;
        #3;
        checks++;
        if (bus.hit_miss !== 1'b0 || bus.Instr_F !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got hit_miss=%b Instr_F=%h expected 0 0", bus.hit_miss, bus.Instr_F);
        end
        checks++;
        if (bus.hit_cnt !== 8'd0 || bus.miss_cnt !== 8'd0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got hit_cnt=%0d miss_cnt=%0d mem_addr=%h expected 0 0 0",
                     bus.hit_cnt, bus.miss_cnt, bus.mem_addr);
        end
    endtask

    task automatic test_cold_miss();
        int stalls;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL cold_cycle0 got hit_miss=%b expected 0", bus.hit_miss);
        end
        step();
        #1;
        checks++;
        if (bus.mem_addr !== 32'h40 || bus.Instr_F !== 32'h0 || bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL cold_request got mem_addr=%h Instr_F=%h hit_miss=%b expected 00000040 0 0",
                     bus.mem_addr, bus.Instr_F, bus.hit_miss);
        end
        wait_hit(stalls);
        checks++;
        if (stalls + 1 !== 21) begin
            errors++;
            $display("FAIL cold_stalls got %0d expected 21", stalls + 1);
        end
        checks++;
        if (bus.Instr_F !== 32'hAAAA0001 || bus.miss_cnt !== 8'd1 || bus.hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cold_hit got Instr_F=%h miss_cnt=%0d hit_cnt=%0d expected AAAA0001 1 0",
                     bus.Instr_F, bus.miss_cnt, bus.hit_cnt);
        end
    endtask

    task automatic test_other_word();
        bus.PC_F = 32'h44;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b1 || bus.Instr_F !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL other_word got hit_miss=%b Instr_F=%h expected 1 BBBB0002", bus.hit_miss, bus.Instr_F);
        end
        step();
        step();
        #1;
        checks++;
        if (bus.hit_cnt !== 8'd2 || bus.miss_cnt !== 8'd1 || bus.mem_addr !== 32'h40 || bus.hit_miss !== 1'b1) begin
            errors++;
            $display("FAIL other_word_cnt got hit_cnt=%0d miss_cnt=%0d mem_addr=%h expected 2 1 00000040",
                     bus.hit_cnt, bus.miss_cnt, bus.mem_addr);
        end
    endtask

    task automatic test_conflict();
        int stalls;
        bus.PC_F = 32'h40 + (32'd8 << 4);
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL conflict_miss got hit_miss=%b expected 0", bus.hit_miss);
        end
        step();
        #1;
        checks++;
        if (bus.mem_addr !== 32'hC0) begin
            errors++;
            $display("FAIL conflict_addr got %h expected 000000C0", bus.mem_addr);
        end
        wait_hit(stalls);
        checks++;
        if (stalls + 1 !== 21 || bus.Instr_F !== 32'hAAAA0003) begin
            errors++;
            $display("FAIL conflict_fill got stalls=%0d Instr_F=%h expected 21 AAAA0003", stalls + 1, bus.Instr_F);
        end
        bus.PC_F = 32'h40;
        #1;
        wait_hit(stalls);
        checks++;
        if (stalls !== 21 || bus.Instr_F !== 32'hAAAA0001 || bus.miss_cnt !== 8'd3) begin
            errors++;
            $display("FAIL conflict_evict got stalls=%0d Instr_F=%h miss_cnt=%0d expected 21 AAAA0001 3",
                     stalls, bus.Instr_F, bus.miss_cnt);
        end
    endtask

    task automatic test_flush_idle();
        int stalls;
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b1 || bus.Instr_F !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL flush_idle_same_cycle got hit_miss=%b Instr_F=%h expected 1 AAAA0001",
                     bus.hit_miss, bus.Instr_F);
        end
        step();
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_after got hit_miss=%b expected 0", bus.hit_miss);
        end
        wait_hit(stalls);
        checks++;
        if (stalls !== 21 || bus.miss_cnt !== 8'd4) begin
            errors++;
            $display("FAIL flush_idle_refill got stalls=%0d miss_cnt=%0d expected 21 4", stalls, bus.miss_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        bus.PC_F = 32'h80;
        #1;
        wait_hit(stalls);
        checks++;
        if (stalls !== 21 || bus.Instr_F !== 32'hAAAA0002 || bus.mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL stale_countdone got stalls=%0d Instr_F=%h mem_addr=%h expected 21 AAAA0002 00000080",
                     stalls, bus.Instr_F, bus.mem_addr);
        end
        bus.PC_F = 32'h84;
        #1;
        checks++;
        if (bus.Instr_F !== 32'hBBBB0003 || bus.miss_cnt !== 8'd5) begin
            errors++;
            $display("FAIL stale_upper got Instr_F=%h miss_cnt=%0d expected BBBB0003 5", bus.Instr_F, bus.miss_cnt);
        end
    endtask

    task automatic test_flush_wait();
        int stalls;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.PC_F  = 32'h40;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_start got hit_miss=%b expected 0", bus.hit_miss);
        end
        for (int i = 0; i < 5; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        wait_hit(stalls);
        checks++;
        if (stalls + 6 !== 42 || bus.miss_cnt !== 8'd7 || bus.Instr_F !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL flush_wait got stalls=%0d miss_cnt=%0d Instr_F=%h expected 42 7 AAAA0001",
                     stalls + 6, bus.miss_cnt, bus.Instr_F);
        end
    endtask

    task automatic test_hit_saturate();
        for (int i = 0; i < 300; i++) step();
        #1;
        checks++;
        if (bus.hit_cnt !== 8'hFF || bus.miss_cnt !== 8'd7 || bus.hit_miss !== 1'b1) begin
            errors++;
            $display("FAIL hit_saturate got hit_cnt=%0d miss_cnt=%0d hit_miss=%b expected 255 7 1",
                     bus.hit_cnt, bus.miss_cnt, bus.hit_miss);
        end
    endtask

    task automatic test_reset_mid_refill();
        model_en    = 1'b0;
        t_countdone = 1'b0;
        bus.PC_F    = 32'h100;
        for (int i = 0; i < 11; i++) step();
        #2 rst_n = 1'b0;
        t_countdone = 1'b1;
        t_f0        = 32'h11111111;
        t_f1        = 32'h22222222;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0 || bus.hit_cnt !== 8'd0 || bus.miss_cnt !== 8'd0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got hit_miss=%b hit_cnt=%0d miss_cnt=%0d mem_addr=%h expected 0 0 0 0",
                     bus.hit_miss, bus.hit_cnt, bus.miss_cnt, bus.mem_addr);
        end
        #1 rst_n = 1'b1;
        bus.PC_F = 32'h40;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL reset_invalid_40 got hit_miss=%b expected 0", bus.hit_miss);
        end
        bus.PC_F = 32'h80;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL reset_invalid_80 got hit_miss=%b expected 0", bus.hit_miss);
        end
        bus.PC_F = 32'h100;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0) begin
            errors++;
            $display("FAIL reset_invalid_100 got hit_miss=%b expected 0", bus.hit_miss);
        end
        #1 t_countdone = 1'b0;
        step();
        #1;
        checks++;
        if (bus.hit_miss !== 1'b0 || bus.miss_cnt !== 8'd1 || bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_new_miss got hit_miss=%b miss_cnt=%0d mem_addr=%h expected 0 1 00000100",
                     bus.hit_miss, bus.miss_cnt, bus.mem_addr);
        end
        step();
        step();
        t_f0        = 32'h33333333;
        t_f1        = 32'h44444444;
        t_countdone = 1'b1;
        step();
        t_countdone = 1'b0;
        #1;
        checks++;
        if (bus.hit_miss !== 1'b1 || bus.Instr_F !== 32'h33333333) begin
            errors++;
            $display("FAIL reset_manual_fill got hit_miss=%b Instr_F=%h expected 1 33333333",
                     bus.hit_miss, bus.Instr_F);
        end
        bus.PC_F = 32'h104;
        #1;
        checks++;
        if (bus.Instr_F !== 32'h44444444) begin
            errors++;
            $display("FAIL reset_manual_upper got Instr_F=%h expected 44444444", bus.Instr_F);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_miss();
        test_other_word();
        test_conflict();
        test_flush_idle();
        test_back_to_back();
        test_flush_wait();
        test_hit_saturate();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
